// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: default widths, opcode constants and the
// decoder control word used by the pipeline registers.
package riscv_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_AW_DEF    = 5;
  localparam int ALUCTRL_W_DEF = 3;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_L_TYPE = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE = 7'b0100011;

  typedef struct packed {
    logic                     RegWrite;
    logic                     ResultSrc;
    logic                     MemWrite;
    logic                     Branch;
    logic                     ALUSrc;
    logic [ALUCTRL_W_DEF-1:0] ALUControl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// Generic pipeline field register: async active-low reset, synchronous clear
// (takes priority) and load enable.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush and a valid bit. Defining
// ID_EX_BUBBLE_CNT_EN adds the BubbleCntE bubble counter port.
module id_ex_pipe_reg
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int ALUCTRL_W = ALUCTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic                 ResultSrcD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [REG_AW-1:0]    Rs1D,
  input  logic [REG_AW-1:0]    Rs2D,
  input  logic [REG_AW-1:0]    RdD,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic                 ResultSrcE,
  output logic                 MemWriteE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [REG_AW-1:0]    Rs1E,
  output logic [REG_AW-1:0]    Rs2E,
  output logic [REG_AW-1:0]    RdE
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]          BubbleCntE
`endif
);

  localparam int CTRL_W = 6 + ALUCTRL_W;
  localparam int DATA_W = 5 * XLEN;
  localparam int IDX_W  = 3 * REG_AW;

  logic              w_en;
  logic [CTRL_W-1:0] w_ctrlD, w_ctrlE;
  logic [DATA_W-1:0] w_dataD, w_dataE;
  logic [IDX_W-1:0]  w_idxD,  w_idxE;

  // Flush wins over stall inside the field register (clear has priority).
  assign w_en    = ~StallE;
  assign w_ctrlD = {ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD, ALUControlD};
  assign w_dataD = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD};
  assign w_idxD  = {Rs1D, Rs2D, RdD};

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .i_en(w_en), .i_clr(FlushE), .i_d(w_ctrlD), .o_q(w_ctrlE)
  );

  pipe_field_reg #(.W(DATA_W)) u_data (
    .clk(clk), .rst_n(rst_n), .i_en(w_en), .i_clr(FlushE), .i_d(w_dataD), .o_q(w_dataE)
  );

  pipe_field_reg #(.W(IDX_W)) u_idx (
    .clk(clk), .rst_n(rst_n), .i_en(w_en), .i_clr(FlushE), .i_d(w_idxD), .o_q(w_idxE)
  );

  assign {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE} = w_ctrlE;
  assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE} = w_dataE;
  assign {Rs1E, Rs2E, RdE} = w_idxE;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic        w_bubble;
  logic [31:0] r_bubbleCnt;

  // A bubble is any edge that actually loads ValidE=0.
  assign w_bubble = FlushE | (~StallE & ~ValidD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_bubbleCnt <= '0;
    else if (w_bubble) r_bubbleCnt <= r_bubbleCnt + 32'd1;
  end

  assign BubbleCntE = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg; covers BubbleCntE when built with
// ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        resultSrc;
    logic        memWrite;
    logic        branch;
    logic        aluSrc;
    logic [2:0]  aluCtrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE, ValidD;
  logic        RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] BubbleCntE;
`endif

  exp_t expQ[$];
  exp_t mdl;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .BubbleCntE(BubbleCntE)
`endif
  );

  function automatic exp_t observed();
    exp_t o;
    o = '{ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
          RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, 32'd0};
`ifdef ID_EX_BUBBLE_CNT_EN
    o.cnt = BubbleCntE;
`endif
    return o;
  endfunction

  // Reference behaviour of one clock edge given the current D-stage inputs.
  function automatic exp_t nextModel(input exp_t cur);
    exp_t n;
    n = cur;
    if (FlushE) begin
      n = '0;
      n.cnt = cur.cnt + 32'd1;
    end else if (!StallE) begin
      n = '{ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD, ALUControlD,
            RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD, cur.cnt};
      if (!ValidD) n.cnt = cur.cnt + 32'd1;
    end
`ifndef ID_EX_BUBBLE_CNT_EN
    n.cnt = 32'd0;
`endif
    return n;
  endfunction

  task automatic clearInputs();
    StallE = 0; FlushE = 0; ValidD = 0;
    RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; BranchD = 0; ALUSrcD = 0;
    ALUControlD = '0; RD1D = '0; RD2D = '0; PCD = '0; PCPlus4D = '0; ImmExtD = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
  endtask

  task automatic checkOutput(input string tag, input exp_t obs, input exp_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one edge: predict, push, clock, then pop and compare.
  task automatic applyStimulus(input string tag);
    exp_t e;
    mdl = nextModel(mdl);
    expQ.push_back(mdl);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput(tag, observed(), e);
  endtask

  initial begin
    clearInputs();
    rst_n = 0;
    {StallE, FlushE} = 2'b00;
    {ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD} = '1;
    ALUControlD = '1; RD1D = '1; RD2D = '1; PCD = '1; PCPlus4D = '1; ImmExtD = '1;
    Rs1D = '1; Rs2D = '1; RdD = '1;
    repeat (2) @(posedge clk);
    #1;
    mdl = '0;
    checkOutput("reset", observed(), mdl);
    @(negedge clk);
    rst_n = 1;

    clearInputs();
    RegWriteD = 1; ResultSrcD = 1; ALUSrcD = 1; ImmExtD = 32'h10; RdD = 5'd5; ValidD = 1;
    applyStimulus("load_lw");

    RD1D = 32'hAAAA; RegWriteD = 0; ResultSrcD = 0; ALUSrcD = 0;
    applyStimulus("stall_preload");
    StallE = 1; RD1D = 32'h5555; ValidD = 0;
    applyStimulus("stall_1");
    applyStimulus("stall_2");
    applyStimulus("stall_3");
    StallE = 0;

    clearInputs();
    MemWriteD = 1; RdD = 5'd7; Rs1D = 5'd3; ImmExtD = 32'h44; ValidD = 1;
    FlushE = 1; StallE = 1;
    applyStimulus("flush_over_stall");

    clearInputs();
    BranchD = 1; PCD = 32'h100; PCPlus4D = 32'h104; ValidD = 0;
    applyStimulus("invalid_bubble");

    for (int i = 0; i < 20; i++) begin
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 4) == 0);
      ValidD = $urandom_range(0, 1);
      {RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD} = 5'($urandom);
      ALUControlD = 3'($urandom);
      RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
      ImmExtD = $urandom;
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
      applyStimulus("random");
    end

    clearInputs();
    RegWriteD = 1; ValidD = 1; RdD = 5'd9; RD2D = 32'h1234;
    applyStimulus("preload_async");
    @(negedge clk);
    rst_n = 0;
    #1;
    checkOutput("async_valid", {215'd0, ValidE}, '0);
    checkOutput("async_regwrite", {215'd0, RegWriteE}, '0);
    mdl = '0;
    checkOutput("async_all", observed(), mdl);
    #2 rst_n = 1;
    clearInputs();
    ValidD = 1; ImmExtD = 32'hBEEF;
    applyStimulus("after_async");

`ifdef ID_EX_BUBBLE_CNT_EN
    @(negedge clk);
    force dut.r_bubbleCnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_bubbleCnt;
    mdl.cnt = 32'hFFFF_FFFF;
    clearInputs();
    FlushE = 1;
    applyStimulus("cnt_wrap");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
